// File: rtl/link_tx.sv
// rtl/link_tx.sv - credit-based link transmitter draining a show-ahead port FIFO
//
// Reads flits from the port's show-ahead output FIFO and drives them onto the
// inter-router link one cycle after the pop. It pops only while enabled, the
// FIFO is non-empty and at least one downstream credit is available.
//
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   enable          - transmit enable; gates new pops only
//   fifo_empty      - FIFO empty flag
//   fifo_dout       - FIFO head, valid while fifo_empty=0
//   fifo_pop        - combinational pop request to the FIFO
//   credit_return   - one-cycle pulse, downstream freed one slot
//   link_valid      - registered flit valid
//   link_data       - registered flit data, held when no pop
//   credit_count    - available downstream credits
//   credit_err      - sticky: credit returned while already full
//   flits_sent      - wrapping count of transmitted flits
module link_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 5,
  parameter int CW         = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_pop,
  input  logic                  credit_return,
  output logic                  link_valid,
  output logic [DATA_WIDTH-1:0] link_data,
  output logic [CW-1:0]         credit_count,
  output logic                  credit_err,
  output logic [15:0]           flits_sent
);

  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

  logic                  link_valid_q, link_valid_d;
  logic [DATA_WIDTH-1:0] link_data_q, link_data_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  credit_err_q, credit_err_d;
  logic [15:0]           flits_sent_q, flits_sent_d;

  always_comb begin
    // Pop depends only on registered credits, so a credit returned this cycle
    // becomes usable next cycle and there is no path from credit_return.
    fifo_pop = enable & ~fifo_empty & (credit_q != '0) & ~reset;

    link_valid_d = fifo_pop;
    link_data_d  = fifo_pop ? fifo_dout : link_data_q;
    flits_sent_d = flits_sent_q + 16'(fifo_pop);

    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    case ({fifo_pop, credit_return})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        // A return while already full saturates and latches the error.
        if (credit_q == CREDITS_MAX) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d = credit_q + CW'(1);
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      credit_q     <= CREDITS_MAX;
      credit_err_q <= 1'b0;
      flits_sent_q <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      flits_sent_q <= flits_sent_d;
    end
  end

  assign link_valid   = link_valid_q;
  assign link_data    = link_data_q;
  assign credit_count = credit_q;
  assign credit_err   = credit_err_q;
  assign flits_sent   = flits_sent_q;

endmodule

// File: tb/tb_link_tx.sv
// tb/tb_link_tx.sv - directed self-checking bench for link_tx
module tb_link_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        fifo_pop;
  logic        credit_return;
  logic        link_valid;
  logic [31:0] link_data;
  logic [2:0]  credit_count;
  logic        credit_err;
  logic [15:0] flits_sent;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  link_tx #(.DATA_WIDTH(32), .CREDITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_pop     (fifo_pop),
    .credit_return(credit_return),
    .link_valid   (link_valid),
    .link_data    (link_data),
    .credit_count (credit_count),
    .credit_err   (credit_err),
    .flits_sent   (flits_sent)
  );

  // Show-ahead FIFO model; reset flushes it by catching the read pointer up.
  logic [31:0] mem [0:31];
  int rd_ptr = 0;
  int wr_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = mem[rd_ptr[4:0]];

  always @(posedge clk) begin
    if (reset) rd_ptr <= wr_ptr;
    else if (fifo_pop) rd_ptr <= rd_ptr + 1;
  end

  task automatic push(input logic [31:0] v);
    mem[wr_ptr[4:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset = 1'b1;
    enable = 1'b1;
    credit_return = 1'b0;

    // Reset
    tick();
    check("rst_valid", link_valid, 0);
    check("rst_data", link_data, 0);
    check("rst_credit", credit_count, 5);
    check("rst_err", credit_err, 0);
    check("rst_flits", flits_sent, 0);
    for (int v = 1; v <= 7; v++) push(v);
    #1;
    check("rst_pop_gated", fifo_pop, 0);

    // Credit exhaustion
    reset = 1'b0;
    #1;
    check("exh_pop0", fifo_pop, 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("exh_valid%0d", i), link_valid, 1);
      check($sformatf("exh_data%0d", i), link_data, i);
      check($sformatf("exh_credit%0d", i), credit_count, 5 - i);
      check($sformatf("exh_pop%0d", i), fifo_pop, (i < 5) ? 1 : 0);
    end
    check("exh_nonempty", fifo_empty, 0);
    tick();
    check("exh_idle_valid", link_valid, 0);
    check("exh_hold_data", link_data, 5);
    check("exh_flits", flits_sent, 5);
    check("exh_pop_zero", fifo_pop, 0);

    // Credit resume
    credit_return = 1'b1;
    #1;
    check("res_no_comb_pop", fifo_pop, 0);
    tick();
    credit_return = 1'b0;
    check("res_credit1", credit_count, 1);
    check("res_valid_still0", link_valid, 0);
    #1;
    check("res_pop", fifo_pop, 1);
    tick();
    check("res_valid", link_valid, 1);
    check("res_data6", link_data, 6);
    check("res_credit0", credit_count, 0);
    check("res_flits", flits_sent, 6);

    // Simultaneous pop and return at credit 3
    enable = 1'b0;
    credit_return = 1'b1;
    tick();
    tick();
    tick();
    check("sim_credit3", credit_count, 3);
    check("sim_no_valid", link_valid, 0);
    enable = 1'b1;
    #1;
    check("sim_pop", fifo_pop, 1);
    tick();
    credit_return = 1'b0;
    check("sim_credit_same", credit_count, 3);
    check("sim_valid", link_valid, 1);
    check("sim_data7", link_data, 7);
    check("sim_flits", flits_sent, 7);
    check("sim_empty", fifo_empty, 1);

    // Overflow
    credit_return = 1'b1;
    tick();
    tick();
    credit_return = 1'b0;
    check("ovf_full", credit_count, 5);
    check("ovf_err_clear", credit_err, 0);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("ovf_sat", credit_count, 5);
    check("ovf_err_set", credit_err, 1);
    for (int i = 0; i < 10; i++) tick();
    check("ovf_err_sticky", credit_err, 1);
    check("ovf_credit_hold", credit_count, 5);

    // Enable low with data and credits, then reset mid-stream
    enable = 1'b0;
    for (int v = 8; v <= 12; v++) push(v);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("en_pop%0d", i), fifo_pop, 0);
      tick();
      check($sformatf("en_valid%0d", i), link_valid, 0);
    end
    enable = 1'b1;
    #1;
    check("en_pop_first", fifo_pop, 1);
    tick();
    check("en_valid_first", link_valid, 1);
    check("en_data8", link_data, 8);
    check("en_credit4", credit_count, 4);
    reset = 1'b1;
    #1;
    check("mid_pop_gated", fifo_pop, 0);
    tick();
    check("mid_valid", link_valid, 0);
    check("mid_data", link_data, 0);
    check("mid_credit", credit_count, 5);
    check("mid_flits", flits_sent, 0);
    check("mid_err", credit_err, 0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/link_tx.md
Name: link_tx

Overview:
- Output-side link transmitter for a router port. Drains the port's show-ahead output FIFO and drives flits onto the inter-router link.
- Flow control is credit-based: one credit equals one free slot in the downstream input FIFO.
- Sits between the port FIFO (push/pop/empty/dout interface) and the neighbour router's input buffer. It is the reader end of that FIFO interface.

Parameters:
- DATA_WIDTH, 32, flit width in bits; must match the FIFO data width.
- CREDITS, 5, downstream buffer depth; initial and maximum credit count.
- CW, $clog2(CREDITS+1), width of the credit counter (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  transmit enable; when low, no new pops are issued.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DATA_WIDTH  FIFO head; valid whenever fifo_empty=0.
- fifo_pop  output  1  combinational pop request to the FIFO.
- credit_return  input  1  one-cycle pulse; downstream freed one slot.
- link_valid  output  1  registered; flit on link_data is valid this cycle.
- link_data  output  DATA_WIDTH  registered flit data.
- credit_count  output  CW  current available credits.
- credit_err  output  1  sticky flag; a credit was returned while already at CREDITS.
- flits_sent  output  16  wrapping count of flits transmitted.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: link_valid=0, link_data=0, credit_count=CREDITS, credit_err=0, flits_sent=0. fifo_pop reads 0 while reset=1.
- Pop rule: fifo_pop = enable & ~fifo_empty & (credit_count != 0) & ~reset.
  - A returning credit does not enable a pop in the same cycle; it is usable from the next cycle.
- FIFO is show-ahead. fifo_dout is the head while non-empty, and the head advances at the edge where fifo_pop=1.
- Transmit, at each edge:
  - link_valid <= fifo_pop.
  - If fifo_pop=1: link_data <= fifo_dout. Otherwise link_data holds its previous value.
- Latency: a flit appears on the link exactly 1 cycle after its pop cycle. Back-to-back pops give back-to-back valid flits, one per cycle, with no bubbles.
- Credit update: credit_count <= credit_count - fifo_pop + credit_return.
  - Simultaneous pop and return leaves the count unchanged.
  - Count never goes below 0; this is guaranteed by the pop rule.
- Credit overflow: credit_return=1, fifo_pop=0 and credit_count==CREDITS together mean the count saturates at CREDITS. credit_err <= 1 and stays set until reset.
- flits_sent increments by 1 on each edge with fifo_pop=1, wrapping 16'hFFFF -> 0.
- enable deasserted mid-stream:
  - No further pops.
  - The flit popped in the last enabled cycle is still presented on the following cycle.
  - Credits continue to be accepted.
- Reset mid-stream:
  - All state returns to reset values on that edge, including credits restored to CREDITS.
  - Any in-flight link_valid is dropped.
  - The FIFO is reset by its own reset at the same time.
- No combinational path from credit_return to fifo_pop, link_valid or link_data.

Test Plan:
- Reset (DATA_WIDTH=32, CREDITS=5): hold reset 1 cycle -> link_valid=0, fifo_pop=0, credit_count=5, credit_err=0, flits_sent=0.
- Credit exhaustion: enable=1, FIFO preloaded with 1..7, no credit returns -> fifo_pop high 5 consecutive cycles; link_data=1,2,3,4,5 with link_valid=1 on cycles 1..5 after start; then credit_count=0, fifo_pop=0 while fifo_empty=0; flits_sent=5.
- Credit resume: from exhaustion, pulse credit_return 1 cycle -> credit_count=1 next cycle, then pop; link_data=6 a cycle later; credit_count=0.
- Simultaneous pop and return: credit_count=3, FIFO non-empty, credit_return=1 during pop -> credit_count stays 3, link_valid=1.
- Overflow: idle (FIFO empty), credit_count=5, pulse credit_return -> credit_count=5, credit_err=1, still 1 after 10 further cycles; cleared only by reset.
- Enable and reset mid-stream: enable=0 with FIFO non-empty and credits 5 -> fifo_pop=0 for 5 cycles, no link_valid. Re-enable, then assert reset during the 2nd pop -> next cycle link_valid=0, credit_count=5, flits_sent=0.
